// File: rtl/mem_word_loader_pkg.sv
// Shared types and helpers for the multi-byte memory word loader.
// Holds the sequencer state encoding, width helpers and the byte-count clamp.
package mem_word_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int BITS_PER_BYTE = 8;

    // Width of the assembled word for a given number of byte lanes.
    function automatic int data_width(input int bytes);
        return BITS_PER_BYTE * bytes;
    endfunction

    // Width needed to hold a byte count in the range 0..bytes.
    function automatic int count_width(input int bytes);
        return $clog2(bytes + 1);
    endfunction

    // Requests larger than the word size are reduced to a full word.
    function automatic int clamp_bytes(input int n, input int max_bytes);
        return (n > max_bytes) ? max_bytes : n;
    endfunction

endpackage

// File: rtl/mem_word_loader_byte_lane_assembler.sv
// Byte-lane register for the read path of mem_word_loader.
// Each lane is written when the byte index selects it; a clear empties the
// word, and a fill request replicates the top valid byte's sign bit into
// every lane at or above fill_n_i.
module byte_lane_assembler
    import mem_word_loader_pkg::*;
#(
    parameter  int BYTES = 4,
    localparam int CNT_W = count_width(BYTES)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [CNT_W-1:0]      lane_i,
    input  logic [7:0]            byte_i,
    input  logic                  fill_i,
    input  logic [CNT_W-1:0]      fill_n_i,
    output logic [8*BYTES-1:0]    word_o
);

    logic [BYTES-1:0][7:0] lane_q;
    logic [BYTES-1:0][7:0] lane_d;
    logic [BYTES-1:0][7:0] captured_s;
    logic                  fill_bit_s;

    // Apply the clear or the single-lane byte capture.
    always_comb begin
        captured_s = lane_q;
        if (clr_i) begin
            captured_s = '0;
        end else if (wr_en_i) begin
            for (int k = 0; k < BYTES; k++) begin
                captured_s[k] = (lane_i == CNT_W'(k)) ? byte_i : lane_q[k];
            end
        end else begin
            captured_s = lane_q;
        end
    end

    // Pick the sign bit of the highest valid byte and fill the lanes above it.
    always_comb begin
        fill_bit_s = 1'b0;
        for (int k = 0; k < BYTES; k++) begin
            fill_bit_s = (fill_n_i == CNT_W'(k + 1)) ? captured_s[k][7] : fill_bit_s;
        end
        for (int k = 0; k < BYTES; k++) begin
            lane_d[k] = (fill_i && (fill_n_i != '0) && (CNT_W'(k) >= fill_n_i))
                        ? {8{fill_bit_s}} : captured_s[k];
        end
    end

    // Lane storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign word_o = lane_q;

endmodule

// File: rtl/mem_word_loader.sv
// Multi-byte memory access sequencer: issues consecutive byte accesses from a
// base address, assembling a little-endian read word or storing a write word
// byte by byte. Sole driver of the memory pins while an access is running.
// Optional build macro MEM_WORD_LOADER_SIGN_EXT_EN adds a sign_ext input that
// sign-extends read words from the last byte fetched.
module mem_word_loader
    import mem_word_loader_pkg::*;
#(
    parameter  int ADDR_W   = 16,
    parameter  int BYTES    = 4,
    parameter  int READ_LAT = 1,
    localparam int DATA_W   = data_width(BYTES),
    localparam int CNT_W    = count_width(BYTES),
    localparam int LAT_W    = $clog2(READ_LAT + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  nbytes,
    input  logic [DATA_W-1:0] wdata,
`ifdef MEM_WORD_LOADER_SIGN_EXT_EN
    input  logic              sign_ext,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_cs,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_e              state_q;
    logic                rw_q;
    logic                sext_q;
    logic [ADDR_W-1:0]   base_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    n_q;
    logic [CNT_W-1:0]    idx_q;
    logic [LAT_W-1:0]    lat_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_cs_q;
    logic                mem_wr_q;
    logic [7:0]          mem_wdata_q;

    logic [CNT_W-1:0]    eff_n_s;
    logic [CNT_W-1:0]    idx_nxt_s;
    logic [ADDR_W-1:0]   addr_nxt_s;
    logic [7:0]          wbyte_nxt_s;
    logic                last_s;
    logic                capture_s;
    logic                clear_s;
    logic                fill_s;
    logic                sext_in_s;

`ifdef MEM_WORD_LOADER_SIGN_EXT_EN
    assign sext_in_s = sign_ext;
`else
    assign sext_in_s = 1'b0;
`endif

    assign eff_n_s    = CNT_W'(clamp_bytes(int'(nbytes), BYTES));
    assign idx_nxt_s  = idx_q + CNT_W'(1);
    assign addr_nxt_s = base_q + ADDR_W'(idx_nxt_s);
    assign last_s     = (idx_q == (n_q - CNT_W'(1)));
    // The read byte is valid in the final wait cycle and is latched at its end.
    assign capture_s  = (state_q == ST_WAIT) && (lat_q == LAT_W'(1));
    assign clear_s    = (state_q == ST_IDLE) && start && !rw;
    assign fill_s     = sext_q && capture_s && last_s;

    // Select the write byte for the next issue cycle.
    always_comb begin
        wbyte_nxt_s = 8'h00;
        for (int k = 0; k < BYTES; k++) begin
            wbyte_nxt_s = (idx_nxt_s == CNT_W'(k)) ? wdata_q[8*k +: 8] : wbyte_nxt_s;
        end
    end

    // Sequencer FSM; memory pins and status outputs are registered here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rw_q        <= 1'b0;
            sext_q      <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            lat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_cs_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rw_q    <= rw;
                        sext_q  <= sext_in_s;
                        base_q  <= base_addr;
                        wdata_q <= wdata;
                        n_q     <= eff_n_s;
                        idx_q   <= '0;
                        if (eff_n_s == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ST_ISSUE;
                            busy_q      <= 1'b1;
                            mem_cs_q    <= 1'b1;
                            mem_wr_q    <= rw;
                            mem_addr_q  <= base_addr;
                            mem_wdata_q <= wdata[7:0];
                        end
                    end
                end
                ST_ISSUE: begin
                    if (rw_q) begin
                        if (last_s) begin
                            state_q  <= ST_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            mem_cs_q <= 1'b0;
                            mem_wr_q <= 1'b0;
                        end else begin
                            idx_q       <= idx_nxt_s;
                            mem_addr_q  <= addr_nxt_s;
                            mem_wdata_q <= wbyte_nxt_s;
                        end
                    end else begin
                        state_q  <= ST_WAIT;
                        mem_cs_q <= 1'b0;
                        lat_q    <= LAT_W'(READ_LAT);
                    end
                end
                ST_WAIT: begin
                    lat_q <= lat_q - LAT_W'(1);
                    if (lat_q == LAT_W'(1)) begin
                        if (last_s) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_ISSUE;
                            idx_q      <= idx_nxt_s;
                            mem_cs_q   <= 1'b1;
                            mem_addr_q <= addr_nxt_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    mem_cs_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                end
            endcase
        end
    end

    byte_lane_assembler #(
        .BYTES (BYTES)
    ) u_lanes (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_i    (clear_s),
        .wr_en_i  (capture_s),
        .lane_i   (idx_q),
        .byte_i   (mem_rdata),
        .fill_i   (fill_s),
        .fill_n_i (n_q),
        .word_o   (rdata)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_cs    = mem_cs_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
